// File: rtl/onehot_decoder_seq_if.sv
// Request/response bundle for onehot_decoder_seq: decode and sweep controls in,
// registered one-hot output and status pulses out.
interface onehot_decoder_seq_if #(
    parameter int SEL_W = 2,
    parameter int OUT_W = 4
);
    logic             en;
    logic             in_valid;
    logic [SEL_W-1:0] in_sel;
    logic             sweep_start;
    logic             sweep_stop;
    logic             sweep_dir;
    logic [OUT_W-1:0] out_onehot;
    logic [SEL_W-1:0] out_idx;
    logic             out_valid;
    logic             err;
    logic             busy;
    logic             sweep_done;

    modport master (
        output en, in_valid, in_sel, sweep_start, sweep_stop, sweep_dir,
        input  out_onehot, out_idx, out_valid, err, busy, sweep_done
    );

    modport slave (
        input  en, in_valid, in_sel, sweep_start, sweep_stop, sweep_dir,
        output out_onehot, out_idx, out_valid, err, busy, sweep_done
    );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with range checking, plus a self-timed sweep that
// walks a single active bit across all outputs with a programmable dwell.
module onehot_decoder_seq #(
    parameter int SEL_W = 2,
    parameter int OUT_W = 4,
    parameter int DWELL = 1,
    parameter int WRAP  = 0
) (
    input logic                 clk,
    input logic                 rst,
    onehot_decoder_seq_if.slave bus
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] DWELL_CNT = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SEL_W-1:0] FIRST_POS = '0;
    localparam logic [SEL_W-1:0] LAST_POS  = SEL_W'(OUT_W - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t           state;
    logic             dir;
    logic [CNT_W-1:0] dwell_cnt;
    logic [OUT_W-1:0] onehot_r;
    logic [SEL_W-1:0] idx_r;
    logic             valid_r;
    logic             err_r;
    logic             busy_r;
    logic             done_r;

    function automatic logic [OUT_W-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            v[i] = (32'(idx) == 32'(i));
        end
        return v;
    endfunction

    // Compared at 32 bits so OUT_W == 2**SEL_W needs no special case.
    logic             sel_in_range;
    logic [SEL_W-1:0] start_pos;
    logic             at_end;
    logic             dwell_expired;
    logic [SEL_W-1:0] step_pos;
    logic             sweep_finish;

    assign sel_in_range  = 32'(bus.in_sel) < 32'(OUT_W);
    assign start_pos     = bus.sweep_dir ? LAST_POS : FIRST_POS;
    assign at_end        = dir ? (idx_r == FIRST_POS) : (idx_r == LAST_POS);
    assign dwell_expired = (dwell_cnt == DWELL_CNT);
    assign step_pos      = at_end ? (dir ? LAST_POS : FIRST_POS)
                                  : (dir ? idx_r - SEL_W'(1) : idx_r + SEL_W'(1));
    assign sweep_finish  = bus.sweep_stop || (dwell_expired && at_end && (WRAP == 0));

    // NOTE: non-blocking assignments only, so every branch sees pre-edge register values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dir       <= 1'b0;
            dwell_cnt <= '0;
            onehot_r  <= '0;
            idx_r     <= '0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle, which also forces them off while en=0.
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            if (bus.en) begin
                case (state)
                    IDLE: begin
                        if (bus.sweep_start) begin
                            state     <= SWEEP;
                            busy_r    <= 1'b1;
                            dir       <= bus.sweep_dir;
                            idx_r     <= start_pos;
                            onehot_r  <= to_onehot(start_pos);
                            valid_r   <= 1'b1;
                            dwell_cnt <= CNT_ONE;
                        end else if (bus.in_valid) begin
                            if (sel_in_range) begin
                                idx_r    <= bus.in_sel;
                                onehot_r <= to_onehot(bus.in_sel);
                                valid_r  <= 1'b1;
                            end else begin
                                onehot_r <= '0;
                                err_r    <= 1'b1;
                            end
                        end
                    end
                    SWEEP: begin
                        if (sweep_finish) begin
                            // out_idx keeps the last shown position after the sweep ends.
                            state     <= IDLE;
                            busy_r    <= 1'b0;
                            onehot_r  <= '0;
                            done_r    <= 1'b1;
                            dwell_cnt <= '0;
                        end else if (dwell_expired) begin
                            idx_r     <= step_pos;
                            onehot_r  <= to_onehot(step_pos);
                            valid_r   <= 1'b1;
                            dwell_cnt <= CNT_ONE;
                        end else begin
                            dwell_cnt <= dwell_cnt + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.out_onehot = onehot_r;
    assign bus.out_idx    = idx_r;
    assign bus.out_valid  = valid_r;
    assign bus.err        = err_r;
    assign bus.busy       = busy_r;
    assign bus.sweep_done = done_r;

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Registered, parametrised successor to the team's 2-to-4 one-hot decoder.
- Adds a configurable output count and a one-cycle registered decode with valid and out-of-range error flags.
- Adds a self-timed sweep mode that walks a single active bit across all outputs, up or down, holding each position for a programmable dwell, with optional wrap.
- Used for channel select, LED scan and ring-enable generation.

Parameters:
- SEL_W, 2, width of select index; OUT_W must be <= 2**SEL_W.
- OUT_W, 4, number of one-hot outputs.
- DWELL, 1, cycles each sweep position is held; must be >= 1. Dwell counter width is clog2(DWELL+1).
- WRAP, 0, sweep behaviour at the last position: 1 = restart at the first position, 0 = finish.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  clock enable; 0 freezes all state.
- in_valid  in  1  decode request, sampled when en=1.
- in_sel  in  SEL_W  index to decode.
- sweep_start  in  1  begin sweep, honoured in IDLE only.
- sweep_stop  in  1  abort sweep, honoured in SWEEP only.
- sweep_dir  in  1  0 = ascending, 1 = descending; sampled with sweep_start.
- out_onehot  out  OUT_W  registered one-hot (or all-zero) output.
- out_idx  out  SEL_W  index of the active bit.
- out_valid  out  1  one-cycle pulse when out_onehot takes a new value.
- err  out  1  one-cycle pulse on out-of-range in_sel.
- busy  out  1  high while in SWEEP.
- sweep_done  out  1  one-cycle pulse on sweep end or abort.

Behaviour:
- Reset: out_onehot=0, out_idx=0, out_valid=0, err=0, busy=0, sweep_done=0, state=IDLE, dwell count=0. rst has priority over en.
- en=0: all registers hold, including the dwell counter. Pulse outputs (out_valid, err, sweep_done) are forced to 0 that cycle.
- States: IDLE and SWEEP. All updates below assume en=1.

IDLE decode:
- On in_valid with in_sel < OUT_W: next cycle out_onehot = 1<<in_sel, out_idx = in_sel, out_valid = 1. Latency is one cycle.
- Without a new request, out_onehot holds its last value; out_valid is 0.
- On in_valid with in_sel >= OUT_W: next cycle out_onehot = 0, out_idx holds, err = 1, out_valid = 0.
- Back-to-back requests are accepted every cycle.

Entering SWEEP:
- sweep_start in IDLE wins over a simultaneous in_valid; that in_valid is dropped.
- Next cycle: busy = 1, position = 0 (dir=0) or OUT_W-1 (dir=1), out_onehot = 1<<position, out_valid = 1, dwell count = 1.

SWEEP stepping:
- Each cycle the dwell count increments.
- When the count reaches DWELL: the position steps by ±1, out_valid pulses, and the count resets to 1.
- With DWELL=1 the position steps every cycle.

SWEEP end position:
- The end position is OUT_W-1 ascending, 0 descending.
- WRAP=1: the next step goes to the opposite end, and the sweep continues indefinitely.
- WRAP=0: when the end position's dwell expires, next cycle out_onehot = 0, busy = 0, sweep_done = 1, out_valid = 0, state = IDLE, and out_idx holds the end position.

Abort and ignored inputs:
- sweep_stop in SWEEP (priority over a simultaneous step): next cycle out_onehot = 0, busy = 0, sweep_done = 1, state = IDLE.
- In SWEEP, in_valid and sweep_start are ignored and no err is raised.
- In IDLE, sweep_stop is ignored.

Corner cases:
- OUT_W=1: a sweep shows bit 0 for DWELL cycles and then finishes (WRAP=0), or holds bit 0 forever (WRAP=1) with an out_valid pulse every DWELL cycles.
- rst asserted mid-sweep: the next cycle shows reset values, and no sweep_done pulse is generated.

Test Plan:
1. Default params, in_valid with in_sel=0,1,2,3 on consecutive cycles -> out_onehot = 0001, 0010, 0100, 1000, each one cycle after its request, with out_valid=1 every cycle.
2. SEL_W=3, OUT_W=5, in_sel=6 -> next cycle out_onehot=00000, err=1, out_valid=0, out_idx unchanged. Then in_sel=4 -> out_onehot=10000.
3. DWELL=3, WRAP=0, sweep_start with dir=0 -> 0001 for 3 cycles, then 0010, 0100, 1000 for 3 cycles each, with 4 out_valid pulses. The cycle after, out_onehot=0000, busy=0, sweep_done=1.
4. DWELL=2, WRAP=1, dir=1 -> sequence 1000, 0100, 0010, 0001, 1000, … with no sweep_done. Assert sweep_stop at the position 0010 -> next cycle 0000, sweep_done=1, busy=0.
5. en=0 for 4 cycles mid-dwell during a sweep -> out_onehot and dwell count frozen with no pulses. Resumes with the remaining dwell cycles only.
6. rst mid-sweep, and separately sweep_start with in_valid in the same cycle -> reset values the next cycle with no sweep_done; in the second case the sweep starts and the decode request is dropped.
